// File: rtl/pmod_ad1_ctrl.sv
// Controller for a Digilent PmodAD1 (two AD7476A channels sharing cs_n/sclk).
// A start request runs one 16-bit SPI frame on both channels. After the frame,
// cs_n stays high for QUIET_TICKS ticks, and then the 12-bit results are
// published with a one-clk done pulse. Every SPI timing step is paced by the
// external tick enable.
module pmod_ad1_ctrl #(
  parameter int QUIET_TICKS = 2  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        sdata0,
  input  logic        sdata1,
  output logic        cs_n,
  output logic        sclk,
  output logic [11:0] data0,
  output logic [11:0] data1,
  output logic        done,
  output logic        busy,
  output logic        frame_err
);

  localparam logic [3:0] QT = 4'(QUIET_TICKS);

  typedef enum logic [1:0] {IDLE, SHIFT, QUIET} state_t;

  state_t      state;
  logic        pending;
  logic [3:0]  bitcnt;   // rising sclk edges taken so far (wraps after 16)
  logic [3:0]  qcnt;
  logic [15:0] sh0, sh1;

  // Frame sequencer: all outputs are registered here. Apart from the pending
  // flag, busy and done clearing, nothing moves without a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      bitcnt    <= '0;
      qcnt      <= '0;
      sh0       <= '0;
      sh1       <= '0;
      cs_n      <= 1'b1;
      sclk      <= 1'b1;
      data0     <= '0;
      data1     <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pending && tick) begin
            // Open the frame. sclk stays high, so the first tick in SHIFT
            // produces the first falling edge.
            cs_n    <= 1'b0;
            bitcnt  <= '0;
            pending <= 1'b0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end else if (start || pending) begin
            // A start arriving together with a tick only arms the request;
            // the frame opens on the next tick.
            pending <= 1'b1;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end

        SHIFT: begin
          if (tick) begin
            if (sclk) begin
              sclk <= 1'b0;
            end else begin
              // Rising edge: the ADC changed data on the preceding falling
              // edge, so the data is stable now.
              sclk   <= 1'b1;
              sh0    <= {sh0[14:0], sdata0};
              sh1    <= {sh1[14:0], sdata1};
              bitcnt <= bitcnt + 4'd1;
              if (bitcnt == 4'd15) begin
                cs_n  <= 1'b1;
                qcnt  <= '0;
                state <= QUIET;
              end
            end
          end
        end

        QUIET: begin
          if (tick) begin
            qcnt <= qcnt + 4'd1;
            if (qcnt + 4'd1 == QT) begin
              // Publish both channels and the error flag together, so that
              // consumers never see a mix of two frames.
              data0     <= sh0[11:0];
              data1     <= sh1[11:0];
              frame_err <= (sh0[15:12] != 4'd0) | (sh1[15:12] != 4'd0);
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_ad1_ctrl.sv
// Directed bench for pmod_ad1_ctrl: a table of ADC words and the results
// expected from them, followed by hand-written multi-cycle scenarios
// (start while busy, back-to-back frames, reset mid-frame, tick gating).
module tb_pmod_ad1_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        sdata0 = 1'b0;
  logic        sdata1 = 1'b0;
  logic        cs_n, sclk, done, busy, frame_err;
  logic [11:0] data0, data1;

  pmod_ad1_ctrl #(.QUIET_TICKS(2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .sdata0(sdata0), .sdata1(sdata1), .cs_n(cs_n), .sclk(sclk),
    .data0(data0), .data1(data1), .done(done), .busy(busy),
    .frame_err(frame_err)
  );

  initial forever #5 clk = ~clk;

  // Tick source: one pulse every 2 clk while enabled. It changes shortly after
  // the rising edge, so the value is stable at the next edge.
  logic tick_en = 1'b1;
  always @(posedge clk) begin
    #2;
    if (!tick_en) tick = 1'b0;
    else          tick = ~tick;
  end

  // Observers
  int ntick = 0, cs_low = 0, done_cnt = 0;
  int fall_cnt = 0, rise_cnt = 0;
  int t_cs = 0, f_cs = 0, t_rise = 0;
  logic [15:0] w0 = '0, w1 = '0;

  always @(posedge clk) begin
    if (tick) begin
      ntick = ntick + 1;
      if (!cs_n) cs_low = cs_low + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  always @(negedge cs_n) begin
    t_cs = ntick;
    f_cs = fall_cnt;
  end

  always @(posedge cs_n) t_rise = ntick;
  always @(posedge sclk) rise_cnt = rise_cnt + 1;

  // ADC model: the next bit, MSB first, is presented on every sclk falling edge.
  always @(negedge sclk) begin
    int k;
    fall_cnt = fall_cnt + 1;
    k = fall_cnt - f_cs - 1;
    if (k >= 0 && k < 16) begin
      sdata0 = w0[15-k];
      sdata1 = w1[15-k];
    end
  end

  // Checking
  int nchk = 0, nerr = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] w0, w1;
    logic [11:0] d0, d1;
    logic        err;
  } vec_t;
  vec_t vecs[5];

  int f0, c0, dc0;

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic begin_frame(input vec_t v);
    w0 = v.w0;
    w1 = v.w1;
    f0 = fall_cnt;
    c0 = cs_low;
    dc0 = done_cnt;
    pulse_start();
  endtask

  task automatic wait_done(input int maxclk, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxclk; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic end_frame(input vec_t v, input string tag);
    bit ok;
    wait_done(400, ok);
    check({tag, "_done_seen"}, ok, 1);
    check({tag, "_data0"}, data0, v.d0);
    check({tag, "_data1"}, data1, v.d1);
    check({tag, "_frame_err"}, frame_err, v.err);
    check({tag, "_busy_at_done"}, busy, 1);
    check({tag, "_latency_ticks"}, ntick - t_cs, 34);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_width"}, done, 0);
    check({tag, "_sclk_low_pulses"}, fall_cnt - f0, 16);
    check({tag, "_cs_low_ticks"}, cs_low - c0, 32);
    check({tag, "_done_count"}, done_cnt - dc0, 1);
  endtask

  task automatic wait_frame_ticks(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!cs_n && (ntick - t_cs) >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_progress", ok, 1);
  endtask

  initial begin
    bit ok;
    int ta, tb, tc, r0;
    logic s_sclk, s_cs;

    vecs[0] = '{16'h0ABC, 16'h0543, 12'hABC, 12'h543, 1'b0};
    vecs[1] = '{16'h0FFF, 16'h1FFF, 12'hFFF, 12'hFFF, 1'b1};
    vecs[2] = '{16'h0123, 16'h0FED, 12'h123, 12'hFED, 1'b0};
    vecs[3] = '{16'h8000, 16'h0000, 12'h000, 12'h000, 1'b1};
    vecs[4] = '{16'h0000, 16'h0800, 12'h000, 12'h800, 1'b0};

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 1);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_data0", data0, 0);
    check("rst_data1", data1, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_start_cs_n", cs_n, 1);

    // Table of single frames
    for (int i = 0; i < 5; i++) begin
      begin_frame(vecs[i]);
      end_frame(vecs[i], $sformatf("vec%0d", i));
      repeat (3) @(negedge clk);
    end

    // Start pulsed while a frame runs: the pulse is ignored.
    begin_frame(vecs[0]);
    wait_frame_ticks(10);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    end_frame(vecs[0], "busy_start");
    repeat (100) @(negedge clk);
    check("busy_start_single_done", done_cnt - dc0, 1);
    check("busy_start_idle_cs_n", cs_n, 1);
    check("busy_start_idle_busy", busy, 0);

    // Back-to-back frames with start held high
    w0 = 16'h0123;
    w1 = 16'h0FED;
    @(negedge clk) start = 1'b1;
    wait_done(400, ok);
    check("b2b_done1", ok, 1);
    ta = ntick;
    wait_done(400, ok);
    check("b2b_done2", ok, 1);
    tb = ntick;
    wait_frame_ticks(1);
    check("b2b_cs_high_ticks", t_cs - t_rise, 3);
    wait_done(400, ok);
    check("b2b_done3", ok, 1);
    tc = ntick;
    start = 1'b0;
    check("b2b_period1", tb - ta, 35);
    check("b2b_period2", tc - tb, 35);
    check("b2b_data0", data0, 12'h123);
    check("b2b_data1", data1, 12'hFED);
    @(negedge clk);
    check("b2b_busy_after", busy, 0);
    repeat (100) @(negedge clk);
    check("b2b_stopped_cs_n", cs_n, 1);

    // Reset after the 8th rising sclk edge
    w0 = 16'h0FFF;
    w1 = 16'h0FFF;
    dc0 = done_cnt;
    r0 = rise_cnt;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rise_cnt - r0 >= 8) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_mid_progress", ok, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_cs_n", cs_n, 1);
    check("rst_mid_sclk", sclk, 1);
    check("rst_mid_data0", data0, 0);
    check("rst_mid_data1", data1, 0);
    check("rst_mid_busy", busy, 0);
    @(negedge clk) rst = 1'b0;
    repeat (100) @(negedge clk);
    check("rst_mid_no_done", done_cnt - dc0, 0);
    check("rst_mid_waits_cs_n", cs_n, 1);
    check("rst_mid_waits_busy", busy, 0);
    begin_frame(vecs[2]);
    end_frame(vecs[2], "after_rst");

    // Tick held low for 20 clk in the middle of a frame
    begin_frame(vecs[0]);
    wait_frame_ticks(9);
    tick_en = 1'b0;
    @(negedge clk);
    s_sclk = sclk;
    s_cs = cs_n;
    repeat (20) begin
      @(negedge clk);
      if (sclk !== s_sclk || cs_n !== s_cs) break;
    end
    check("gate_sclk_frozen", sclk, s_sclk);
    check("gate_cs_frozen", cs_n, s_cs);
    check("gate_no_done", done_cnt - dc0, 0);
    tick_en = 1'b1;
    end_frame(vecs[0], "gated");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
